pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised elastic pipeline register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB).
//  Carries a datapath bundle and a control-bit bundle with a valid/ready handshake.
//  Has a 2-entry skid buffer, synchronous flush, and bubble masking of control bits.
//  Has a saturating stall counter for performance monitoring.
// PARAMETERS
//  DATA_W  51  datapath bundle width (e.g. ALU result, branch target, store data, dest reg)
//  CTRL_W  5   control bundle width (e.g. MemToReg, RegWrite, MemRead, MemWrite, Branch)
//  CNT_W   16  stall counter width
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous squash of all held entries
//  clr_stats  in   1       synchronous clear of stall_cnt
//  in_valid   in   1       upstream entry present
//  in_ready   out  1       stage accepts an entry this cycle
//  in_data    in   DATA_W  upstream datapath bundle
//  in_ctrl    in   CTRL_W  upstream control bundle
//  out_valid  out  1       entry presented downstream
//  out_ready  in   1       downstream accepts the entry
//  out_data   out  DATA_W  head-entry datapath bundle
//  out_ctrl   out  CTRL_W  head-entry control bundle; all zero whenever out_valid=0
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//  Storage: main register (head), skid register (second entry).
//  State encoding: main_v and skid_v.
//  States:
//    EMPTY (main_v=0, skid_v=0)
//    FULL  (main_v=1, skid_v=0)
//    SKID  (main_v=1, skid_v=1)
//  Combinational outputs: in_ready = ~skid_v; out_valid = main_v.
//  Transitions when flush=0:
//   EMPTY: in_xfer -> FULL, main <= in. Otherwise stay EMPTY.
//   FULL:  in_xfer & out_xfer -> FULL, main <= in.
//          in_xfer only -> SKID, skid <= in.
//          out_xfer only -> EMPTY.
//          Neither -> hold.
//   SKID:  in_ready=0, so no input is accepted.
//          out_xfer -> FULL, main <= skid.
//          Otherwise hold.
//  Latency: entry accepted at edge N is on out_* after edge N when the stage was EMPTY.
//  Throughput: one entry per cycle with out_ready=1, no gaps.
//  Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
//  flush (highest priority over all handshakes):
//   - next state is EMPTY; any same-cycle in_xfer is discarded.
//   - out_xfer in the flush cycle still counts as consumed by downstream.
//   - after the flush edge: out_valid=0, out_ctrl=0, in_ready=1.
//   - stall_cnt is unaffected.
//  Bubble masking: out_ctrl = main_v ? main_ctrl : 0.
//   out_data holds the last value while invalid; its value is undefined for the consumer.
//  stall_cnt:
//   - +1 on each cycle with out_valid & ~out_ready; saturates at 2^CNT_W-1, no wrap.
//   - clr_stats clears it to 0 and wins over a same-cycle increment.
//  Reset (rst_n=0, immediate, not clock-gated):
//   main_v=skid_v=0; all data/ctrl registers 0; stall_cnt=0.
//   Outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
//   Reset mid-operation discards all held entries.
// TESTING
//  1 Reset mid-traffic (SKID state), assert rst_n=0 between edges -> out_valid=0, out_ctrl=0,
//    in_ready=1, stall_cnt=0 with no clock edge; data regs 0.
//  2 Stream 16 entries, data 0x0001..0x0010, out_ready=1 -> each appears 1 cycle after accept,
//    back-to-back, in order; in_ready stays 1.
//  3 Push A=0x1111, B=0x2222 with out_ready=0 -> in_ready=0, C=0x3333 held upstream.
//    Then out_ready=1 -> A, B, C delivered on consecutive cycles.
//  4 SKID state + flush=1 + in_valid=1 (D=0x4444) -> next cycle out_valid=0, out_ctrl=0,
//    in_ready=1; A, B, D are never emitted.
//  5 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).
//    Then clr_stats with the stall still present -> stall_cnt=0 next cycle, then 1.
//  6 in_ctrl=5'b11111 with in_valid=0 from EMPTY -> out_ctrl=5'b00000 every cycle.
//    Then one valid entry -> out_ctrl=5'b11111 for exactly the valid cycle.

Source files
------------

// File: rtl/pipe_stage_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_reg_if
// Description : Handshake bundle for pipe_stage_skid_reg. It carries both the
//               upstream (in_*) and downstream (out_*) sides of the stage.
//               slave  : the stage itself (consumes in_*, produces out_*)
//               master : the environment around the stage
// Ports       : in_valid/in_ready/in_data/in_ctrl   upstream handshake
//               out_valid/out_ready/out_data/out_ctrl downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_reg_if #(
    parameter int DATA_W = 51,
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_reg
// Description : Elastic pipeline register with a 2-entry skid buffer,
//               synchronous flush, bubble masking of control bits and a
//               saturating stall counter.
// Ports       : clk        clock, all state updates on posedge
//               rst_n      asynchronous active-low reset
//               flush      synchronous squash of all held entries
//               clr_stats  synchronous clear of stall_cnt
//               bus        handshake bundle (slave side)
//               stall_cnt  cycles with out_valid=1 and out_ready=0
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
    parameter int DATA_W = 51,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   flush,
    input  wire logic                   clr_stats,
    pipe_stage_skid_reg_if.slave        bus,
    output logic [CNT_W-1:0]            stall_cnt
);

    // Encoding chosen so that bit 0 is main_v and bit 1 is skid_v.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_main_v;
    logic w_skid_v;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_main_v   = r_state[0];
    assign w_skid_v   = r_state[1];
    assign w_in_xfer  = bus.in_valid & ~w_skid_v;
    assign w_out_xfer = w_main_v & bus.out_ready;

    assign bus.in_ready  = ~w_skid_v;
    assign bus.out_valid = w_main_v;
    assign bus.out_data  = r_main_data;
    // Bubbles never carry live control bits downstream.
    assign bus.out_ctrl  = w_main_v ? r_main_ctrl : '0;
    assign stall_cnt     = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Stall statistics run independently of flush.
            if (clr_stats) begin
                r_stall_cnt <= '0;
            end else if (w_main_v && !bus.out_ready && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (flush) begin
                // Data registers keep stale contents; only validity is dropped.
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_xfer) begin
                            r_main_data <= bus.in_data;
                            r_main_ctrl <= bus.in_ctrl;
                            r_state     <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        case ({w_in_xfer, w_out_xfer})
                            2'b11: begin
                                r_main_data <= bus.in_data;
                                r_main_ctrl <= bus.in_ctrl;
                            end
                            2'b10: begin
                                r_skid_data <= bus.in_data;
                                r_skid_ctrl <= bus.in_ctrl;
                                r_state     <= ST_SKID;
                            end
                            2'b01: begin
                                r_state <= ST_EMPTY;
                            end
                            default: begin
                            end
                        endcase
                    end
                    ST_SKID: begin
                        if (w_out_xfer) begin
                            r_main_data <= r_skid_data;
                            r_main_ctrl <= r_skid_ctrl;
                            r_state     <= ST_FULL;
                        end
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid_reg
// Description : Directed self-checking bench for pipe_stage_skid_reg with
//               hand-computed expected values. Inputs change 1 time unit
//               after posedge; outputs are checked before the next posedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

    localparam int DATA_W = 51;
    localparam int CTRL_W = 5;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             clr_stats;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp;
    int n_err;

    pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_skid_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .clr_stats (clr_stats),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] c);
        bus.in_valid = v;
        bus.in_data  = d[DATA_W-1:0];
        bus.in_ctrl  = c;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        clr_stats     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'h0, 5'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_in_ready",  {63'h0, bus.in_ready},  64'h1);
        chk("rst_out_ctrl",  {59'h0, bus.out_ctrl},  64'h0);

        // ---- 1: asynchronous reset while in SKID -------------------------
        drive(1'b1, 64'h0AAA, 5'h0A); tick();
        drive(1'b1, 64'h0BBB, 5'h0B); tick();
        drive(1'b0, 64'h0, 5'h0);
        chk("t1_in_ready_skid", {63'h0, bus.in_ready}, 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("t1_out_ctrl",  {59'h0, bus.out_ctrl},  64'h0);
        chk("t1_in_ready",  {63'h0, bus.in_ready},  64'h1);
        chk("t1_stall_cnt", {60'h0, stall_cnt},     64'h0);
        chk("t1_out_data",  {13'h0, bus.out_data},  64'h0);
        #1 rst_n = 1'b1;
        tick();

        // ---- 2: 16-entry back-to-back stream -----------------------------
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 64'(i), 5'(i));
            chk("t2_in_ready", {63'h0, bus.in_ready}, 64'h1);
            tick();
            chk("t2_out_valid", {63'h0, bus.out_valid}, 64'h1);
            chk("t2_out_data",  {13'h0, bus.out_data},  64'(i));
            chk("t2_out_ctrl",  {59'h0, bus.out_ctrl},  64'(i & 31));
        end
        drive(1'b0, 64'h0, 5'h0);
        tick();
        chk("t2_drain_valid", {63'h0, bus.out_valid}, 64'h0);

        // ---- 3: backpressure fills skid, then drains in order ------------
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h1111, 5'h01); tick();
        drive(1'b1, 64'h2222, 5'h02);
        chk("t3_in_ready_b", {63'h0, bus.in_ready}, 64'h1);
        tick();
        drive(1'b1, 64'h3333, 5'h03);
        chk("t3_in_ready_c", {63'h0, bus.in_ready}, 64'h0);
        tick();
        chk("t3_hold_ready", {63'h0, bus.in_ready}, 64'h0);
        chk("t3_hold_data",  {13'h0, bus.out_data}, 64'h1111);
        bus.out_ready = 1'b1;
        chk("t3_a", {13'h0, bus.out_data}, 64'h1111);
        tick();
        chk("t3_b", {13'h0, bus.out_data}, 64'h2222);
        chk("t3_b_ready", {63'h0, bus.in_ready}, 64'h1);
        tick();
        drive(1'b0, 64'h0, 5'h0);
        chk("t3_c", {13'h0, bus.out_data}, 64'h3333);
        chk("t3_c_valid", {63'h0, bus.out_valid}, 64'h1);
        tick();
        chk("t3_empty", {63'h0, bus.out_valid}, 64'h0);

        // ---- 4: flush from SKID with a same-cycle input -------------------
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h1111, 5'h11); tick();
        drive(1'b1, 64'h2222, 5'h12); tick();
        drive(1'b1, 64'h4444, 5'h14);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 64'h0, 5'h0);
        chk("t4_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("t4_out_ctrl",  {59'h0, bus.out_ctrl},  64'h0);
        chk("t4_in_ready",  {63'h0, bus.in_ready},  64'h1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_emit", {63'h0, bus.out_valid}, 64'h0);
        end

        // ---- 5: stall counter saturation and clear ------------------------
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h5555, 5'h05);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        drive(1'b0, 64'h0, 5'h0);
        chk("t5_cnt_start", {60'h0, stall_cnt}, 64'h0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t5_cnt", {60'h0, stall_cnt}, 64'((k > 15) ? 15 : k));
        end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("t5_clr", {60'h0, stall_cnt}, 64'h0);
        tick();
        chk("t5_after_clr", {60'h0, stall_cnt}, 64'h1);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_drained", {63'h0, bus.out_valid}, 64'h0);

        // ---- 6: control masking on bubbles --------------------------------
        drive(1'b0, 64'h6666, 5'h1F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_bubble_ctrl", {59'h0, bus.out_ctrl}, 64'h0);
        end
        drive(1'b1, 64'h6666, 5'h1F);
        tick();
        drive(1'b0, 64'h0, 5'h1F);
        chk("t6_valid_ctrl", {59'h0, bus.out_ctrl}, 64'h1F);
        chk("t6_valid",      {63'h0, bus.out_valid}, 64'h1);
        tick();
        chk("t6_after_ctrl", {59'h0, bus.out_ctrl}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
